// File: rtl/qisp_fe_pkg.sv
// qisp_fe_pkg: types and constants shared by the fetch-stage modules.
package qisp_fe_pkg;

   localparam int INSTR_W = 16;

   localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      STALL = 2'd2,
      DROP  = 2'd3
   } fe_state_t;

endpackage

// File: rtl/fetch_buf.sv
// fetch_buf: one-entry word buffer that parks a fetched word while decode holds.
module fetch_buf
   import qisp_fe_pkg::*;
(
   input  logic               clk,
   input  logic               a_rst,
   input  logic               i_load,
   input  logic               i_clr,
   input  logic [INSTR_W-1:0] i_data,
   output logic               o_valid,
   output logic [INSTR_W-1:0] o_data
);

   // Clear wins over load so a redirect always empties the buffer.
   always_ff @(posedge clk or posedge a_rst) begin
      if (a_rst) begin
         o_valid <= 1'b0;
         o_data  <= '0;
      end else if (i_clr) begin
         o_valid <= 1'b0;
      end else if (i_load) begin
         o_valid <= 1'b1;
         o_data  <= i_data;
      end
   end

endmodule

// File: rtl/fetch_seq.sv
// fetch_seq: owns the PC and the instruction-memory read handshake, feeding
// fetched words to fe_unit with hold buffering and jump redirect handling.
module fetch_seq
   import qisp_fe_pkg::*;
#(
   parameter int            AW       = 16,
   parameter logic [AW-1:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int            PC_STEP  = 1
)(
   input  logic               clk,
   input  logic               a_rst,
   input  logic               i_hold,
   input  logic               i_jmp,
   input  logic [AW-1:0]      i_jmp_addr,
   output logic               o_mem_req,
   output logic [AW-1:0]      o_mem_addr,
   input  logic               i_mem_ack,
   input  logic [INSTR_W-1:0] i_mem_data,
   output logic               o_fe_rdy,
   output logic [INSTR_W-1:0] o_fe_data,
   output logic               o_fe_hold_clr,
   output logic [AW-1:0]      o_pc,
   output logic               o_busy
);

   localparam logic [AW-1:0] STEP = AW'(PC_STEP);

   fe_state_t          r_state;
   logic [AW-1:0]      r_pc;

   fe_state_t          w_state_n;
   logic [AW-1:0]      w_pc_n;
   logic [AW-1:0]      w_pc_inc;
   logic               w_req_n;
   logic [AW-1:0]      w_addr_n;
   logic               w_rdy_n;
   logic [INSTR_W-1:0] w_data_n;
   logic               w_hclr_n;
   logic [AW-1:0]      w_opc_n;
   logic               w_busy_n;
   logic               w_buf_load;
   logic               w_buf_clr;
   logic               w_buf_valid;
   logic [INSTR_W-1:0] w_buf_data;

   assign w_pc_inc = r_pc + STEP;
   assign w_busy_n = (w_state_n == REQ) || (w_state_n == DROP);

   fetch_buf u_buf (
      .clk     (clk),
      .a_rst   (a_rst),
      .i_load  (w_buf_load),
      .i_clr   (w_buf_clr),
      .i_data  (i_mem_data),
      .o_valid (w_buf_valid),
      .o_data  (w_buf_data)
   );

   always_comb begin
      w_state_n  = r_state;
      w_pc_n     = r_pc;
      w_req_n    = o_mem_req;
      w_addr_n   = o_mem_addr;
      w_rdy_n    = 1'b0;
      w_data_n   = o_fe_data;
      w_hclr_n   = 1'b0;
      w_opc_n    = o_pc;
      w_buf_load = 1'b0;
      w_buf_clr  = 1'b0;

      if (i_jmp) begin
         w_pc_n    = i_jmp_addr;
         w_buf_clr = 1'b1;
         w_hclr_n  = 1'b1;
         // A read still in flight must complete before the target can be
         // requested; if its ack lands now (even in DROP) issue the target at once.
         if ((r_state == REQ || r_state == DROP) && !i_mem_ack) begin
            w_state_n = DROP;
         end else begin
            w_state_n = REQ;
            w_req_n   = 1'b1;
            w_addr_n  = i_jmp_addr;
         end
      end else begin
         case (r_state)
            IDLE: begin
               w_state_n = REQ;
               w_req_n   = 1'b1;
               w_addr_n  = r_pc;
            end
            REQ: begin
               if (i_mem_ack) begin
                  if (i_hold) begin
                     w_buf_load = 1'b1;
                     w_req_n    = 1'b0;
                     w_state_n  = STALL;
                  end else begin
                     w_rdy_n  = 1'b1;
                     w_data_n = i_mem_data;
                     w_opc_n  = o_mem_addr;
                     w_pc_n   = w_pc_inc;
                     w_addr_n = w_pc_inc;
                  end
               end
            end
            STALL: begin
               if (!i_hold && w_buf_valid) begin
                  w_rdy_n   = 1'b1;
                  w_data_n  = w_buf_data;
                  w_opc_n   = r_pc;
                  w_pc_n    = w_pc_inc;
                  w_addr_n  = w_pc_inc;
                  w_req_n   = 1'b1;
                  w_buf_clr = 1'b1;
                  w_state_n = REQ;
               end
            end
            DROP: begin
               if (i_mem_ack) begin
                  w_addr_n  = r_pc;
                  w_state_n = REQ;
               end
            end
            default: w_state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge a_rst) begin
      if (a_rst) begin
         r_state       <= IDLE;
         r_pc          <= RESET_PC;
         o_mem_req     <= 1'b0;
         o_mem_addr    <= RESET_PC;
         o_fe_rdy      <= 1'b0;
         o_fe_data     <= '0;
         o_fe_hold_clr <= 1'b0;
         o_pc          <= RESET_PC;
         o_busy        <= 1'b0;
      end else begin
         r_state       <= w_state_n;
         r_pc          <= w_pc_n;
         o_mem_req     <= w_req_n;
         o_mem_addr    <= w_addr_n;
         o_fe_rdy      <= w_rdy_n;
         o_fe_data     <= w_data_n;
         o_fe_hold_clr <= w_hclr_n;
         o_pc          <= w_opc_n;
         o_busy        <= w_busy_n;
      end
   end

endmodule
